srec_emitter: RTL and testbench
===============================

Name: srec_emitter

Overview:
- Memory-to-text counterpart of the SREC loader.
- Reads a word range out of the memory controller and serialises it as Motorola S-record ASCII (S3 data records, one S7 terminator) on a byte stream with valid/ready handshake.
- Used after simulation or from debug logic to dump program/data memory (e.g. 0x8002_0000 region) for comparison against the loaded image.
- Sits beside fetch/srec loader on the shared memory-controller port; the system mux grants it the port while busy=1.

Parameters:
- BYTES_PER_RECORD, 16, data bytes per S3 record; multiple of 4, range 4..32.
- EOL_CHAR, 8'h0A, single line terminator emitted after every record.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- start_address  input  32 [0:31]  first byte address; must be word-aligned.
- byte_count  input  32 [0:31]  number of bytes to dump.
- mem_address  output  32 [0:31]  word address to memory controller.
- mem_wren  output  1  always 0 (read-only master).
- mem_data_in  output  32 [0:31]  write data to memory, tied 0.
- mem_data_out  input  32 [0:31]  read data; valid exactly one cycle after mem_address is presented.
- char_out  output  8  ASCII character.
- char_valid  output  1  char_out is valid.
- char_ready  input  1  sink accepts char when valid&&ready at a rising edge.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the final EOL of S7 is accepted.

Behaviour:
- Reset values: mem_address=0, mem_wren=0, mem_data_in=0, char_out=0, char_valid=0, busy=0, done=0, FSM=IDLE, counters/buffer cleared.
- Reset mid-dump aborts immediately. No partial record completion. Next start begins fresh.
- Byte order is big-endian: byte at address A is mem_data_out[0:7], A+1 is [8:15], and so on.
- Hex digits are uppercase ('0'-'9','A'-'F'), most significant nibble first.
- FSM transitions:
  - IDLE -> FETCH on start. Latches start_address into rec_addr and byte_count into remaining.
  - FETCH: issues ceil(n/4) sequential word reads, one per cycle, where n = min(remaining, BYTES_PER_RECORD). Captures each word into the record buffer one cycle later. Accumulates checksum sum. Goes to HDR after the last capture.
  - HDR: emits 'S','3', then count as 2 hex digits (count = n+5), then rec_addr as 8 hex digits.
  - DATA: emits 2n hex digits from the buffer.
  - CSUM: emits 2 hex digits of checksum = ~(low byte of sum of count, 4 address bytes, n data bytes).
  - EOL: emits EOL_CHAR. Then rec_addr += n and remaining -= n. Goes to FETCH if remaining>0, else TERM.
  - TERM: emits 'S','7','0','5', start_address as 8 hex digits, checksum over 05 and the address bytes, then EOL_CHAR. Goes to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Handshake:
  - char_out/char_valid are held stable while char_valid && !char_ready.
  - The FSM advances one character per accepted transfer.
  - char_valid=0 in IDLE, FETCH and DONE. Zero-throughput stalls of any length are legal.
- Boundaries:
  - byte_count=0: no S3 records; S7 only.
  - byte_count not a multiple of 4: the last word is read fully, but only the remaining bytes are emitted.
  - byte_count not a multiple of BYTES_PER_RECORD: the final record is shorter.
  - rec_addr wraps modulo 2^32.
  - start while busy is ignored.
  - Sum arithmetic is 8-bit wraparound.

Decomposition:
- Package srec_defs:
  - ASCII constants ('S','3','7', EOL).
  - FSM state encoding.
  - S3 header overhead (5) and S7 count (8'h05).
- Sub-module hex_ascii: combinational 4-bit nibble -> 8-bit uppercase ASCII.
- Buffer, counters and FSM stay in srec_emitter.

Test Plan:
- T1: mem[0x8002_0000]=0x3C1D8002, mem[0x8002_0004]=0x27BDFFFC; start, byte_count=8, char_ready=1 -> stream "S30D800200003C1D800227BDFFFCB6\n" then "S7058002000078\n", then a done pulse.
- T2: byte_count=0, start_address=0x8002_0000 -> only "S7058002000078\n"; done one cycle after the last accept.
- T3: byte_count=20 with BYTES_PER_RECORD=16 -> two S3 records, counts 0x15 and 0x09, addresses 80020000 and 80020010; checksums match a software model.
- T4: byte_count=6 -> one record with count 0x0B and 12 data hex digits; the second word's low 2 bytes are not emitted.
- T5: char_ready toggled randomly (about 30% high) on T1 data -> identical character sequence; char_out is stable whenever valid&&!ready; mem_wren is never 1.
- T6: assert reset during DATA of T3 -> all outputs return to reset values asynchronously; a subsequent start with T1 data reproduces the exact T1 stream.

Source files
------------

// File: rtl/srec_emitter_pkg.sv
// Shared definitions for the S-record emitter: ASCII constants, FSM encoding
// and record overhead constants.
package srec_defs;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_HDR, S_DATA, S_CSUM, S_EOL, S_TERM, S_DONE
    } state_t;

    localparam logic [7:0] CH_S   = 8'h53;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_3   = 8'h33;
    localparam logic [7:0] CH_5   = 8'h35;
    localparam logic [7:0] CH_7   = 8'h37;
    localparam logic [7:0] CH_EOL = 8'h0A;

    localparam logic [7:0] S3_OVERHEAD = 8'd5;
    localparam logic [7:0] S7_COUNT    = 8'h05;

    function automatic logic [7:0] addr_sum(input logic [31:0] a);
        return a[31:24] + a[23:16] + a[15:8] + a[7:0];
    endfunction

endpackage

// File: rtl/srec_emitter_if.sv
// Memory-controller port plus the outgoing character stream of the emitter.
interface srec_emitter_if;
    logic [0:31] mem_address;
    logic        mem_wren;
    logic [0:31] mem_data_in;
    logic [0:31] mem_data_out;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;

    modport master (
        output mem_address, mem_wren, mem_data_in, char_out, char_valid,
        input  mem_data_out, char_ready
    );
    modport slave (
        input  mem_address, mem_wren, mem_data_in, char_out, char_valid,
        output mem_data_out, char_ready
    );
endinterface

// File: rtl/srec_emitter_hex_ascii.sv
// Nibble to uppercase ASCII hex digit.
module hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb ascii = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
endmodule

// File: rtl/srec_emitter.sv
// Dumps a memory byte range as S3 records plus one S7 terminator, one ASCII
// character per valid/ready transfer.
module srec_emitter
    import srec_defs::*;
#(
    parameter int         BYTES_PER_RECORD = 16,
    parameter logic [7:0] EOL_CHAR         = CH_EOL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [0:31] start_address,
    input  logic [0:31] byte_count,
    output logic        busy,
    output logic        done,
    srec_emitter_if.master io
);
    localparam int IW = $clog2(BYTES_PER_RECORD);

    state_t state, state_nx;
    logic [31:0] rec_addr, remaining, first_addr, mem_addr_q, rem_nx, word;
    logic [BYTES_PER_RECORD-1:0][7:0] rbuf;
    logic [7:0] sum, word_sum, rec_count, term_csum, cbyte, dbyte, ch, hex_ch;
    logic [5:0] n;
    logic [3:0] nw, fcnt, widx, nib;
    logic [6:0] cidx;
    logic       accept, last_char, use_hex, valid;

    assign word      = io.mem_data_out;
    assign n         = (remaining < 32'(BYTES_PER_RECORD)) ? remaining[5:0] : 6'(BYTES_PER_RECORD);
    assign nw        = 4'((n + 6'd3) >> 2);
    assign rec_count = 8'(n) + S3_OVERHEAD;
    assign rem_nx    = remaining - 32'(n);
    assign term_csum = ~(S7_COUNT + addr_sum(first_addr));
    assign widx      = fcnt - 4'd1;
    assign accept    = io.char_valid && io.char_ready;

    // Only bytes inside the record feed the checksum; a partial last word is read whole.
    always_comb begin
        word_sum = 8'h00;
        for (int b = 0; b < 4; b++)
            if (({widx, 2'b00} + 6'(b)) < n) word_sum = word_sum + word[31-8*b -: 8];
    end

    always_comb begin
        last_char = 1'b0;
        case (state)
            S_HDR:   last_char = (cidx == 7'd11);
            S_DATA:  last_char = (cidx == {n, 1'b0} - 7'd1);
            S_CSUM:  last_char = (cidx == 7'd1);
            S_EOL:   last_char = 1'b1;
            S_TERM:  last_char = (cidx == 7'd14);
            default: last_char = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (byte_count == 32'd0) ? S_TERM : S_FETCH;
            S_FETCH: if (fcnt == nw) state_nx = S_HDR;
            S_HDR:   if (accept && last_char) state_nx = S_DATA;
            S_DATA:  if (accept && last_char) state_nx = S_CSUM;
            S_CSUM:  if (accept && last_char) state_nx = S_EOL;
            S_EOL:   if (accept) state_nx = (rem_nx != 32'd0) ? S_FETCH : S_TERM;
            S_TERM:  if (accept && last_char) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FETCH cycle k presents word k and captures word k-1 (one-cycle read latency).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_addr   <= '0;
            remaining  <= '0;
            first_addr <= '0;
            mem_addr_q <= '0;
            rbuf       <= '0;
            sum        <= '0;
            fcnt       <= '0;
            cidx       <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rec_addr   <= start_address;
                    remaining  <= byte_count;
                    first_addr <= start_address;
                    mem_addr_q <= start_address;
                    fcnt       <= '0;
                    cidx       <= '0;
                end
                S_FETCH: begin
                    mem_addr_q <= mem_addr_q + 32'd4;
                    fcnt       <= (fcnt == nw) ? 4'd0 : fcnt + 4'd1;
                    if (fcnt == 4'd0) sum <= rec_count + addr_sum(rec_addr);
                    else begin
                        sum <= sum + word_sum;
                        for (int b = 0; b < 4; b++)
                            rbuf[IW'({widx, 2'b00}) + IW'(b)] <= word[31-8*b -: 8];
                    end
                end
                S_EOL: if (accept) begin
                    rec_addr   <= rec_addr + 32'(n);
                    remaining  <= rem_nx;
                    mem_addr_q <= rec_addr + 32'(n);
                    cidx       <= '0;
                end
                default: if (accept) cidx <= last_char ? 7'd0 : cidx + 7'd1;
            endcase
        end
    end

    assign cbyte = ~sum;
    assign dbyte = rbuf[cidx[IW:1]];

    always_comb begin
        valid = 1'b0; use_hex = 1'b0; ch = 8'h00; nib = 4'h0;
        case (state)
            S_HDR: begin
                valid = 1'b1;
                if (cidx == 7'd0)      ch = CH_S;
                else if (cidx == 7'd1) ch = CH_3;
                else begin use_hex = 1'b1; nib = 4'({rec_count, rec_addr} >> {7'd11 - cidx, 2'b00}); end
            end
            S_DATA: begin valid = 1'b1; use_hex = 1'b1; nib = cidx[0] ? dbyte[3:0] : dbyte[7:4]; end
            S_CSUM: begin valid = 1'b1; use_hex = 1'b1; nib = cidx[0] ? cbyte[3:0] : cbyte[7:4]; end
            S_EOL:  begin valid = 1'b1; ch = EOL_CHAR; end
            S_TERM: begin
                valid = 1'b1;
                case (cidx)
                    7'd0:    ch = CH_S;
                    7'd1:    ch = CH_7;
                    7'd2:    ch = CH_0;
                    7'd3:    ch = CH_5;
                    7'd14:   ch = EOL_CHAR;
                    default: begin use_hex = 1'b1; nib = 4'({first_addr, term_csum} >> {7'd13 - cidx, 2'b00}); end
                endcase
            end
            default: ;
        endcase
    end

    hex_ascii u_hex (.nibble(nib), .ascii(hex_ch));

    assign io.char_out    = use_hex ? hex_ch : ch;
    assign io.char_valid  = valid;
    assign io.mem_address = mem_addr_q;
    assign io.mem_wren    = 1'b0;
    assign io.mem_data_in = '0;
    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_srec_emitter.sv
// Directed bench for srec_emitter: expected characters come from literals or a
// software S-record model and are queued, then popped on every accepted char.
module tb_srec_emitter;
    localparam int BPR = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [0:31] start_address = '0;
    logic [0:31] byte_count = '0;
    logic        busy, done;
    logic [31:0] mem_w [0:15];
    logic [7:0]  exp_q [$];
    int checks = 0;
    int errors = 0;

    srec_emitter_if io ();

    srec_emitter #(.BYTES_PER_RECORD(BPR), .EOL_CHAR(8'h0A)) dut (
        .clock(clock), .reset(reset), .start(start), .start_address(start_address),
        .byte_count(byte_count), .busy(busy), .done(done), .io(io)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:6] == 26'h2000800) return mem_w[a[5:2]];
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clock) io.mem_data_out <= mem_rd(io.mem_address);

    function automatic logic [7:0] hexc(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h41 + {4'h0, v} - 8'd10;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_hex(input logic [7:0] b);
        exp_q.push_back(hexc(b[7:4]));
        exp_q.push_back(hexc(b[3:0]));
    endtask

    task automatic push_dump(input logic [31:0] addr, input logic [31:0] cnt);
        logic [31:0] a, rem, n, w;
        logic [7:0] cs, b;
        a = addr; rem = cnt;
        while (rem != 0) begin
            n = (rem < BPR) ? rem : BPR;
            cs = 8'(n + 5);
            push_str("S3");
            push_hex(cs);
            for (int k = 3; k >= 0; k--) begin
                b = 8'(a >> (8 * k)); cs += b; push_hex(b);
            end
            for (int i = 0; i < int'(n); i++) begin
                w = mem_rd((a + i) & 32'hFFFF_FFFC);
                b = 8'(w >> (8 * (3 - int'((a + i) & 3))));
                cs += b; push_hex(b);
            end
            push_hex(~cs);
            push_str("\n");
            a += n; rem -= n;
        end
        cs = 8'h05;
        push_str("S705");
        for (int k = 3; k >= 0; k--) begin
            b = 8'(addr >> (8 * k)); cs += b; push_hex(b);
        end
        push_hex(~cs);
        push_str("\n");
    endtask

    task automatic do_start(input logic [31:0] addr, input logic [31:0] cnt);
        @(posedge clock); #1;
        io.char_ready = 1'b0; start_address = addr; byte_count = cnt; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Consumes characters until done (or stop_after accepts), checking each against the queue.
    task automatic run_dump(input int pct, input int stop_after, input int max_cyc);
        int acc, last_acc, wren_bad, stab_bad;
        bit got_done, prev_hold, stop;
        logic [7:0] prev_ch, e;
        acc = 0; last_acc = -10; wren_bad = 0; stab_bad = 0;
        got_done = 0; prev_hold = 0; stop = 0; prev_ch = 8'h00;
        io.char_ready = ($urandom_range(0, 99) < pct);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            if (io.mem_wren !== 1'b0) wren_bad++;
            if (prev_hold && (io.char_valid !== 1'b1 || io.char_out !== prev_ch)) stab_bad++;
            if (done === 1'b1) begin
                got_done = 1;
                check("done_after_last_accept", c - last_acc, 1);
                check("busy_low_at_done", busy, 0);
                break;
            end
            if (io.char_valid && io.char_ready) begin
                check("char_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("char", io.char_out, e);
                end
                acc++; last_acc = c;
                if (stop_after > 0 && acc == stop_after) stop = 1;
            end
            prev_hold = io.char_valid && !io.char_ready;
            prev_ch = io.char_out;
            @(posedge clock); #1;
            if (stop) break;
            io.char_ready = ($urandom_range(0, 99) < pct);
        end
        if (stop_after == 0) begin
            check("done_seen", got_done, 1);
            check("queue_drained", exp_q.size(), 0);
        end
        check("wren_never", wren_bad, 0);
        check("hold_stable", stab_bad, 0);
    endtask

    task automatic check_reset_vals();
        check("rst_mem_address", io.mem_address, 0);
        check("rst_mem_wren", io.mem_wren, 0);
        check("rst_mem_data_in", io.mem_data_in, 0);
        check("rst_char_out", io.char_out, 0);
        check("rst_char_valid", io.char_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        mem_w[0] = 32'h3C1D_8002; mem_w[1] = 32'h27BD_FFFC;
        mem_w[2] = 32'h0011_2233; mem_w[3] = 32'hDEAD_BEEF;
        mem_w[4] = 32'hA5A5_5A5A; mem_w[5] = 32'h0102_0304;
        for (int i = 6; i < 16; i++) mem_w[i] = 32'h1000_0000 * i + i;
        io.char_ready = 1'b0;
        #2 check_reset_vals();
        @(negedge clock) reset = 1'b0;

        // T1: two words, literal expected stream
        do_start(32'h8002_0000, 8);
        push_str("S30D800200003C1D800227BDFFFCB6\n");
        push_str("S7058002000078\n");
        run_dump(100, 0, 500);

        // T2: empty range, terminator only
        do_start(32'h8002_0000, 0);
        push_str("S7058002000078\n");
        run_dump(100, 0, 500);

        // T3: two records, the second one short
        do_start(32'h8002_0000, 20);
        push_dump(32'h8002_0000, 20);
        run_dump(100, 0, 1000);

        // T4: partial word; start pulse while busy must be ignored
        do_start(32'h8002_0004, 6);
        start_address = 32'h1234_5678; byte_count = 32'd40; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        push_dump(32'h8002_0004, 6);
        run_dump(100, 0, 500);

        // Address wrap across 2^32 between records
        do_start(32'hFFFF_FFF8, 24);
        push_dump(32'hFFFF_FFF8, 24);
        run_dump(100, 0, 1000);

        // T5: T1 data under random backpressure
        do_start(32'h8002_0000, 8);
        push_str("S30D800200003C1D800227BDFFFCB6\n");
        push_str("S7058002000078\n");
        run_dump(30, 0, 3000);

        // T6: reset in the middle of a T3 data field, then a clean T1 dump
        do_start(32'h8002_0000, 20);
        push_dump(32'h8002_0000, 20);
        run_dump(100, 15, 500);
        #1 reset = 1'b1;
        #1 check_reset_vals();
        exp_q.delete();
        @(negedge clock) reset = 1'b0;
        do_start(32'h8002_0000, 8);
        push_str("S30D800200003C1D800227BDFFFCB6\n");
        push_str("S7058002000078\n");
        run_dump(100, 0, 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
